mand_escape_seq: RTL and testbench

// - Downstream sequencer and escape tracker for the 128x128 Mandelbrot iteration unit.
// - Bus master on the unit's slave port: kicks an iteration pass, waits it out, scans xn/yn back.
// - Records per-pixel escape pass in a local 16384x9 count RAM that the host reads over a slave port.

---
 rtl/mand_escape_seq.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_mand_escape_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mand_escape_seq.sv
// mand_escape_seq -- sequencer and escape tracker for the Mandelbrot iteration unit.
//
// Acts as bus master on the iteration unit's slave port: each pass writes the
// kick register, waits out the iteration pass, then reads xn[i] and yn[i] back
// for every pixel. The first pass in which a pixel escapes is recorded in a
// local count RAM (one 9-bit entry per pixel) that the host reads over a slave port.
//
// Optional feature macro: MAND_ESC_IRQ_EN adds an 'irq' output that is raised on
// completion and cleared by any host CTRL write.
//
// Parameters
//   PASS_CYCLES  cycles waited after each kick (must cover pixels + pipeline + 2)
//   RD_LAT       read latency of the iteration unit data bus (>= 1)
//   IDX_W        log2 of the pixel count; 14 for the 128x128 unit
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   host_address[14:0]  [14]=0: count RAM index; [14]=1: 0=CTRL, 1=STATUS
//   host_read           read strobe, host_data_out valid one cycle later
//   host_write          write strobe, only CTRL is writable
//   host_data_in[31:0]  host write data
//   host_data_out[31:0] host read data
//   m_address[15:0]     0xfffc=kick, 0x8000|i=xn[i], 0xC000|i=yn[i]
//   m_read, m_write     single-cycle strobes to the iteration unit
//   m_be[3:0]           byte enables
//   m_data_out[31:0]    write data (always 0; only the kick is written)
//   m_data_in[31:0]     read data from the iteration unit
//   irq                 (MAND_ESC_IRQ_EN only) completion interrupt
module mand_escape_seq #(
    parameter int PASS_CYCLES = 16400,
    parameter int RD_LAT      = 1,
    parameter int IDX_W       = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [14:0] host_address,
    input  logic        host_read,
    input  logic        host_write,
    input  logic [31:0] host_data_in,
    output logic [31:0] host_data_out,
    output logic [15:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [3:0]  m_be,
    output logic [31:0] m_data_out,
    input  logic [31:0] m_data_in
`ifdef MAND_ESC_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int NPIX   = 1 << IDX_W;
    localparam int WAIT_W = $clog2(PASS_CYCLES);
    localparam int LAT_W  = $clog2(RD_LAT + 1);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(PASS_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT);
    localparam logic [IDX_W-1:0]  IDX_LAST  = {IDX_W{1'b1}};
    localparam logic [IDX_W:0]    ESC_FULL  = {1'b1, {IDX_W{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_KICK,
        S_WAIT,
        S_SCAN_X,
        S_SCAN_Y,
        S_UPDATE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [7:0]          pass_q, pass_d;
    logic [7:0]          maxp_q, maxp_d;
    logic [IDX_W:0]      esc_q, esc_d;
    logic                done_q, done_d;
    logic                xn30_q, xn30_d;
    logic                yn30_q, yn30_d;

    // Count RAM: port A is the sequencer (read in SCAN_Y, write in CLEAR/UPDATE),
    // port B is the host read port.
    logic [8:0]          cnt_ram [NPIX];
    logic [8:0]          ent_q;
    logic                ram_we;
    logic [8:0]          ram_wdata;

    logic                busy;
    logic                reg_sel;
    logic                ctrl_wr;
    logic                ctrl_clr_only;
    logic                start_ok;
    logic [14:0]         esc_ext;
    logic [31:0]         status_word;
    logic                unused_bits;

    assign busy    = (state_q != S_IDLE);
    assign reg_sel = host_address[14];
    assign ctrl_wr = host_write && reg_sel && (host_address[13:0] == 14'd0);

`ifdef MAND_ESC_IRQ_EN
    // A CTRL write with bit1 set only acknowledges the interrupt.
    assign ctrl_clr_only = ctrl_wr && host_data_in[1];
`else
    assign ctrl_clr_only = 1'b0;
`endif

    assign start_ok = ctrl_wr && !ctrl_clr_only && host_data_in[0]
                      && (state_q == S_IDLE) && (host_data_in[15:8] != 8'd0);

    assign esc_ext     = 15'(esc_q);
    assign status_word = {1'b0, esc_ext, pass_q, 6'd0, done_q, busy};

    // Bits of wide buses that this block does not decode.
    assign unused_bits = ^{host_address, host_data_in, m_data_in};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            lat_q   <= '0;
            pass_q  <= '0;
            maxp_q  <= '0;
            esc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            lat_q   <= lat_d;
            pass_q  <= pass_d;
            maxp_q  <= maxp_d;
            esc_q   <= esc_d;
            done_q  <= done_d;
        end
    end

    // Latched escape bits are data; they are always rewritten before use.
    always_ff @(posedge clock) begin
        xn30_q <= xn30_d;
        yn30_q <= yn30_d;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        lat_d      = lat_q;
        pass_d     = pass_q;
        maxp_d     = maxp_q;
        esc_d      = esc_q;
        done_d     = done_q;
        xn30_d     = xn30_q;
        yn30_d     = yn30_q;
        ram_we     = 1'b0;
        ram_wdata  = 9'd0;
        m_address  = 16'd0;
        m_read     = 1'b0;
        m_write    = 1'b0;
        m_be       = 4'd0;
        m_data_out = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                    pass_d  = '0;
                    esc_d   = '0;
                    done_d  = 1'b0;
                    maxp_d  = host_data_in[15:8];
                end
            end
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_wdata = 9'd0;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_KICK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_KICK: begin
                m_write   = 1'b1;
                m_address = 16'hfffc;
                m_be      = 4'hf;
                wait_d    = WAIT_LOAD;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    idx_d   = '0;
                    lat_d   = '0;
                    state_d = S_SCAN_X;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_SCAN_X: begin
                // Strobe on the first cycle, hold address until data arrives.
                m_address = 16'h8000 | 16'(idx_q);
                m_be      = 4'hf;
                m_read    = (lat_q == '0);
                if (lat_q == LAT_LAST) begin
                    xn30_d  = m_data_in[30];
                    lat_d   = '0;
                    state_d = S_SCAN_Y;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_SCAN_Y: begin
                m_address = 16'hc000 | 16'(idx_q);
                m_be      = 4'hf;
                m_read    = (lat_q == '0);
                if (lat_q == LAT_LAST) begin
                    yn30_d  = m_data_in[30];
                    lat_d   = '0;
                    state_d = S_UPDATE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_UPDATE: begin
                // Exponent MSB set means |v| >= 2, and also flags inf/NaN.
                if ((xn30_q || yn30_q) && !ent_q[8]) begin
                    ram_we    = 1'b1;
                    ram_wdata = {1'b1, pass_q + 8'd1};
                    esc_d     = esc_q + 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    lat_d   = '0;
                    state_d = S_SCAN_X;
                end
            end
            S_NEXT: begin
                pass_d = pass_q + 8'd1;
                if ((pass_q + 8'd1 == maxp_q) || (esc_q == ESC_FULL)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_KICK;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            cnt_ram[idx_q] <= ram_wdata;
        end
    end

    // Entry read for the pixel being scanned; valid in UPDATE.
    always_ff @(posedge clock) begin
        if (state_q == S_SCAN_Y) begin
            ent_q <= cnt_ram[idx_q];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            host_data_out <= 32'd0;
        end else if (host_read) begin
            if (!reg_sel) begin
                host_data_out <= {23'd0, cnt_ram[host_address[IDX_W-1:0]]};
            end else if (host_address[13:0] == 14'd0) begin
                host_data_out <= {16'd0, maxp_q, 8'd0};
            end else if (host_address[13:0] == 14'd1) begin
                host_data_out <= status_word;
            end else begin
                host_data_out <= 32'd0;
            end
        end
    end

`ifdef MAND_ESC_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (state_d == S_DONE && state_q != S_DONE) begin
            irq_q <= 1'b1;
        end else if (ctrl_wr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mand_escape_seq.sv
// Directed bench for mand_escape_seq on a 16-pixel instance with a small
// behavioural model of the iteration unit's slave port.
module tb_mand_escape_seq;

    localparam int PC = 40;
    localparam int RL = 2;
    localparam int IW = 4;
    localparam int NP = 1 << IW;

    localparam logic [14:0] A_CTRL   = 15'h4000;
    localparam logic [14:0] A_STATUS = 15'h4001;

    logic        clock = 1'b0;
    logic        reset;
    logic [14:0] host_address;
    logic        host_read;
    logic        host_write;
    logic [31:0] host_data_in;
    logic [31:0] host_data_out;
    logic [15:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [3:0]  m_be;
    logic [31:0] m_data_out;
    logic [31:0] m_data_in;
`ifdef MAND_ESC_IRQ_EN
    logic        irq;
`endif

    mand_escape_seq #(
        .PASS_CYCLES(PC),
        .RD_LAT     (RL),
        .IDX_W      (IW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .host_address (host_address),
        .host_read    (host_read),
        .host_write   (host_write),
        .host_data_in (host_data_in),
        .host_data_out(host_data_out),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_be         (m_be),
        .m_data_out   (m_data_out),
        .m_data_in    (m_data_in)
`ifdef MAND_ESC_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Iteration unit model state
    int          mode      = 0;
    int          kick_base = 0;
    int          kicks     = 0;
    int          bad_wr    = 0;
    int          both_cnt  = 0;
    int          cyc       = 0;
    int          last_kick = 0;
    int          min_gap   = 1000000;
    logic [31:0] pipe [RL];

    function automatic logic [31:0] model_val(input logic [15:0] a, input int passnum);
        logic [31:0] v;
        v = 32'h0;
        if (mode == 1) begin
            v = 32'h3f80_0000;
            if (a == 16'h8005 && passnum >= 2) v = 32'h4000_0000;
        end else if (mode == 2) begin
            if (a[15:14] == 2'b11 && passnum == 1) v = 32'h7f80_0000;
        end
        return v;
    endfunction

    always @(posedge clock) begin
        pipe[0] <= m_read ? model_val(m_address, kicks - kick_base) : 32'h0;
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
        if (m_write) begin
            if (m_address == 16'hfffc && m_be == 4'hf && m_data_out == 32'h0) begin
                kicks <= kicks + 1;
                if (kicks > 0 && (cyc - last_kick) < min_gap) min_gap <= cyc - last_kick;
                last_kick <= cyc;
            end else begin
                bad_wr <= bad_wr + 1;
            end
        end
        if (m_read && m_write) both_cnt <= both_cnt + 1;
        cyc <= cyc + 1;
    end

    assign m_data_in = pipe[RL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [14:0] a, input logic [31:0] d);
        @(negedge clock);
        host_address = a;
        host_data_in = d;
        host_write   = 1'b1;
        @(negedge clock);
        host_write   = 1'b0;
    endtask

    task automatic host_rd(input logic [14:0] a, output logic [31:0] d);
        @(negedge clock);
        host_address = a;
        host_read    = 1'b1;
        @(negedge clock);
        host_read    = 1'b0;
        d            = host_data_out;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            host_rd(A_STATUS, s);
            if (s[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_entries(input string tag, input int sel_idx,
                               input logic [31:0] sel_val, input logic [31:0] other_val);
        logic [31:0] d;
        for (int i = 0; i < NP; i++) begin
            host_rd(15'(i), d);
            chk($sformatf("%s_entry%0d", tag, i), d, (i == sel_idx) ? sel_val : other_val);
        end
    endtask

    initial begin
        logic [31:0] d;
        int kb;
        bit seen;

        reset        = 1'b1;
        host_address = '0;
        host_read    = 1'b0;
        host_write   = 1'b0;
        host_data_in = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_m_read",    {31'd0, m_read},  32'd0);
        chk("rst_m_write",   {31'd0, m_write}, 32'd0);
        chk("rst_m_address", {16'd0, m_address}, 32'd0);
        chk("rst_m_be",      {28'd0, m_be}, 32'd0);
        chk("rst_m_data",    m_data_out, 32'd0);
        chk("rst_host_data", host_data_out, 32'd0);
        reset = 1'b0;
        host_rd(A_STATUS, d);
        chk("rst_status", d, 32'd0);
`ifdef MAND_ESC_IRQ_EN
        chk("rst_irq", {31'd0, irq}, 32'd0);
`endif

        // max_passes = 0: start ignored
        host_wr(A_CTRL, 32'h0000_0001);
        repeat (100) @(negedge clock);
        host_rd(A_STATUS, d);
        chk("maxp0_status", d, 32'd0);
        chk("maxp0_kicks", kicks, 32'd0);

        // Three passes, nothing escapes
        mode      = 0;
        kick_base = kicks;
        host_wr(A_CTRL, 32'h0000_0301);
        wait_idle("zero");
        host_rd(A_STATUS, d);
        chk("zero_status", d, 32'h0000_0302);
        chk("zero_kicks", kicks - kick_base, 32'd3);
        chk("zero_kick_gap_ok", {31'd0, min_gap >= PC}, 32'd1);
        chk_entries("zero", -1, 32'h0, 32'h0);
`ifdef MAND_ESC_IRQ_EN
        chk("irq_set", {31'd0, irq}, 32'd1);
        host_wr(A_CTRL, 32'h0000_0002);
        @(negedge clock);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        host_rd(A_STATUS, d);
        chk("irq_clr_status", d, 32'h0000_0302);
`endif

        // Pixel 5 escapes from pass 2; CTRL write while busy is ignored
        mode      = 1;
        kick_base = kicks;
        host_wr(A_CTRL, 32'h0000_0301);
        repeat (10) @(negedge clock);
        host_wr(A_CTRL, 32'h0000_0501);
        wait_idle("px5");
        host_rd(A_STATUS, d);
        chk("px5_status", d, 32'h0001_0302);
        chk("px5_kicks", kicks - kick_base, 32'd3);
        chk_entries("px5", 5, 32'h102, 32'h0);

        // Every yn infinite on pass 1: stops early with all pixels escaped
        mode      = 2;
        kick_base = kicks;
        host_wr(A_CTRL, 32'h0000_0a01);
        wait_idle("inf");
        host_rd(A_STATUS, d);
        chk("inf_status", d, 32'h0010_0102);
        chk("inf_kicks", kicks - kick_base, 32'd1);
        chk_entries("inf", -1, 32'h0, 32'h101);

        // Reset while waiting after a kick
        mode = 0;
        kb   = kicks;
        host_wr(A_CTRL, 32'h0000_0201);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (kicks != kb) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rwait_kick_seen", {31'd0, seen}, 32'd1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rwait_m_read",  {31'd0, m_read},  32'd0);
        chk("rwait_m_write", {31'd0, m_write}, 32'd0);
        reset = 1'b0;
        host_rd(A_STATUS, d);
        chk("rwait_status", d, 32'd0);
        kb = kicks;
        repeat (100) @(negedge clock);
        chk("rwait_no_kick", kicks - kb, 32'd0);

        // Reset while a yn read is outstanding
        host_wr(A_CTRL, 32'h0000_0201);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (m_read && m_address[15:14] == 2'b11) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rscan_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rscan_m_read",    {31'd0, m_read},  32'd0);
        chk("rscan_m_write",   {31'd0, m_write}, 32'd0);
        chk("rscan_m_address", {16'd0, m_address}, 32'd0);
        reset = 1'b0;
        host_rd(A_STATUS, d);
        chk("rscan_status", d, 32'd0);

        // Clean run after the aborted ones
        mode      = 1;
        kick_base = kicks;
        host_wr(A_CTRL, 32'h0000_0201);
        wait_idle("rerun");
        host_rd(A_STATUS, d);
        chk("rerun_status", d, 32'h0001_0202);
        chk("rerun_kicks", kicks - kick_base, 32'd2);
        chk_entries("rerun", 5, 32'h102, 32'h0);

        chk("bus_both_strobes", both_cnt, 32'd0);
        chk("bus_bad_writes", bad_wr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
